counter_ngay: RTL and testbench
===============================

Name: counter_ngay

Overview:
- Day-of-month counter for the calendar chain; sits directly upstream of the month counter.
- Increments on the hour-chain carry and wraps at the days-in-month limit supplied by the month counter (dim).
- Emits carry_out, which drives the month counter's inc_auto.
- Also tracks day-of-week, and supports manual set (inc/dec) and direct load from the UI.

Parameters:
- RESET_DAY, 1: day value after reset (1..31).
- RESET_WDAY, 0: weekday after reset (0..6, 0 = Sunday).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- inc_auto  input  1  one-cycle pulse from the hour counter carry.
- inc_manual  input  1  one-cycle manual +1 pulse.
- dec_manual  input  1  one-cycle manual -1 pulse.
- load_en  input  1  one-cycle direct load strobe.
- load_day  input  5  day to load.
- load_wday  input  3  weekday to load.
- dim  input  6  days in current month, from the month counter (28..31).
- value  output  5  current day, 1..31, registered.
- weekday  output  3  current weekday, 0..6, registered.
- carry_out  output  1  registered one-cycle pulse on auto wrap, to month inc_auto.
- last_day  output  1  combinational; high when value == dim_eff.

Behaviour:
- Reset (async, rst=1): value=RESET_DAY, weekday=RESET_WDAY, carry_out=0. last_day follows combinationally.
- dim_eff = dim when 28 <= dim <= 31; otherwise dim_eff = 31.
- carry_out defaults to 0 every cycle. It is high for exactly one cycle after an auto wrap.
- Each cycle exactly one action applies, in this priority order:
  1. Clamp, when value > dim_eff:
     - value <= dim_eff; weekday unchanged; carry_out=0.
     - All strobes that cycle are dropped.
     - Covers month change (e.g. 31 to April) and leap change (Feb 29 to non-leap).
  2. Load, when load_en:
     - Day: load_day=0 -> 1; load_day > dim_eff -> dim_eff; otherwise load_day.
     - Weekday: load_wday=7 -> 0; otherwise load_wday.
     - No carry.
  3. Manual decrement, when dec_manual:
     - value==1 -> dim_eff; otherwise value-1.
     - weekday==0 -> 6; otherwise weekday-1.
     - No carry.
  4. Manual increment, when inc_manual:
     - value==dim_eff -> 1; otherwise value+1.
     - weekday==6 -> 0; otherwise weekday+1.
     - No carry.
  5. Auto increment, when inc_auto:
     - value==dim_eff -> value <= 1 and carry_out <= 1; otherwise value+1.
     - weekday advances mod 7.
  6. None of the above: hold.
- An auto pulse that loses arbitration to a higher-priority action is dropped, not queued.
- Manual wraps never produce carry_out; manual month edits are the month counter's own job.
- Latency:
  - value, weekday and carry_out update on the clock edge after the qualifying input.
  - carry_out reaches the month counter in the same cycle value shows 1.
- dim lag: dim is registered downstream of month value, so it lags a month change by one cycle. The clamp rule absorbs this; a transient value > dim_eff lasts at most one cycle after dim settles.
- Widths:
  - value arithmetic is 5-bit unsigned, compared against dim_eff[4:0]; 31 fits.
  - weekday arithmetic is 3-bit; the value 7 is never stored.
- Reset mid-operation: rst overrides any strobe in the same cycle; carry_out is forced low immediately.

Test Plan:
- Reset: assert rst while value=15 -> value=1, weekday=0, carry_out=0 without a clock edge; release, no strobes -> outputs hold.
- Auto wrap: dim=30, value=30, weekday=6, inc_auto pulse -> value=1, weekday=0, carry_out=1 for exactly one cycle; next inc_auto -> value=2, carry_out=0.
- Leap February:
  - dim=29, value=28, two inc_auto pulses -> 29, then 1 with carry.
  - Repeat with dim=28 -> wrap after 28.
  - value=29 then dim changes 29->28 -> next cycle value=28, no carry.
- Manual set: value=1, weekday=0, dec_manual -> value=dim_eff (31 with dim=31), weekday=6, carry_out=0; then inc_manual at 31 -> value=1, carry_out=0.
- Priority:
  - inc_auto+inc_manual+dec_manual together at value=10, weekday=3 -> value=9, weekday=2, carry_out=0.
  - load_en with load_day=31, dim=30, load_wday=7 -> value=30, weekday=0.
- Clamp vs strobe: value=31, dim switches to 30 and inc_auto pulses in the same cycle -> value=30, weekday unchanged, carry_out=0, auto pulse dropped; dim=45 -> treated as 31.

Source files
------------

// File: rtl/counter_ngay.sv
`default_nettype none
// ============================================================================
// Module      : counter_ngay
// Description : Day-of-month counter for the calendar chain. It advances on the
//               hour-chain carry and wraps at the days-in-month limit from the
//               month counter. It also tracks the weekday, accepts manual
//               +1/-1 and direct loads, and emits a one-cycle carry on auto
//               wrap to the month counter.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_ngay #(
  parameter int unsigned RESET_DAY  = 1,
  parameter int unsigned RESET_WDAY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_auto,
  input  logic       inc_manual,
  input  logic       dec_manual,
  input  logic       load_en,
  input  logic [4:0] load_day,
  input  logic [2:0] load_wday,
  input  logic [5:0] dim,
  output logic [4:0] value,
  output logic [2:0] weekday,
  output logic       carry_out,
  output logic       last_day
);

  localparam logic [4:0] C_RESET_DAY  = 5'(RESET_DAY);
  localparam logic [2:0] C_RESET_WDAY = 3'(RESET_WDAY);
  localparam logic [4:0] C_DAY_MAX    = 5'd31;
  localparam logic [2:0] C_WDAY_MAX   = 3'd6;

  logic [4:0] value_q, value_d;
  logic [2:0] wday_q,  wday_d;
  logic       carry_q, carry_d;
  logic [4:0] w_dim_eff;

  // An out-of-range month length (garbage while the month counter settles)
  // is treated as a 31-day month so the day value never collapses.
  always_comb begin
    w_dim_eff = C_DAY_MAX;
    if ((dim >= 6'd28) && (dim <= 6'd31)) begin
      w_dim_eff = dim[4:0];
    end
  end

  // Select exactly one action per cycle, highest priority first.
  always_comb begin
    value_d = value_q;
    wday_d  = wday_q;
    carry_d = 1'b0;
    if (value_q > w_dim_eff) begin
      // The month just shrank under us: clamp and drop every strobe.
      value_d = w_dim_eff;
    end else if (load_en) begin
      if (load_day == 5'd0) begin
        value_d = 5'd1;
      end else if (load_day > w_dim_eff) begin
        value_d = w_dim_eff;
      end else begin
        value_d = load_day;
      end
      wday_d = (load_wday == 3'd7) ? 3'd0 : load_wday;
    end else if (dec_manual) begin
      value_d = (value_q == 5'd1) ? w_dim_eff : value_q - 5'd1;
      wday_d  = (wday_q == 3'd0) ? C_WDAY_MAX : wday_q - 3'd1;
    end else if (inc_manual) begin
      // Manual wraps stay local: the month is edited on its own counter.
      value_d = (value_q == w_dim_eff) ? 5'd1 : value_q + 5'd1;
      wday_d  = (wday_q == C_WDAY_MAX) ? 3'd0 : wday_q + 3'd1;
    end else if (inc_auto) begin
      if (value_q == w_dim_eff) begin
        value_d = 5'd1;
        carry_d = 1'b1;
      end else begin
        value_d = value_q + 5'd1;
      end
      wday_d = (wday_q == C_WDAY_MAX) ? 3'd0 : wday_q + 3'd1;
    end
  end

  // State register; reset wins over any strobe and drops the carry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= C_RESET_DAY;
      wday_q  <= C_RESET_WDAY;
      carry_q <= 1'b0;
    end else begin
      value_q <= value_d;
      wday_q  <= wday_d;
      carry_q <= carry_d;
    end
  end

  assign value     = value_q;
  assign weekday   = wday_q;
  assign carry_out = carry_q;
  assign last_day  = (value_q == w_dim_eff);

endmodule
`default_nettype wire

// File: tb/tb_counter_ngay.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_ngay
// Description : Self-checking bench for counter_ngay: directed calendar cases
//               with literal expectations, then randomized strobes and month
//               lengths checked every cycle against a calendar model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_ngay;

  logic       clk = 1'b0;
  logic       rst;
  logic       inc_auto, inc_manual, dec_manual, load_en;
  logic [4:0] load_day;
  logic [2:0] load_wday;
  logic [5:0] dim;
  logic [4:0] value;
  logic [2:0] weekday;
  logic       carry_out;
  logic       last_day;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Calendar model state (plain integers).
  int m_day, m_wd, m_carry;

  counter_ngay #(.RESET_DAY(1), .RESET_WDAY(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .inc_auto  (inc_auto),
    .inc_manual(inc_manual),
    .dec_manual(dec_manual),
    .load_en   (load_en),
    .load_day  (load_day),
    .load_wday (load_wday),
    .dim       (dim),
    .value     (value),
    .weekday   (weekday),
    .carry_out (carry_out),
    .last_day  (last_day)
  );

  always #5 clk = ~clk;

  function automatic int month_len(input int d);
    return (d >= 28 && d <= 31) ? d : 31;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Calendar model: one rule per cycle, expressed with modular arithmetic.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_day = 1; m_wd = 0; m_carry = 0;
    end else begin
      int n;
      n = month_len(int'(dim));
      m_carry = 0;
      if (m_day > n) begin
        m_day = n;
      end else if (load_en) begin
        m_day = (load_day == 0) ? 1 : ((int'(load_day) > n) ? n : int'(load_day));
        m_wd  = int'(load_wday) % 7;
      end else if (dec_manual) begin
        m_day = (m_day - 2 + n) % n + 1;
        m_wd  = (m_wd + 6) % 7;
      end else if (inc_manual) begin
        m_day = m_day % n + 1;
        m_wd  = (m_wd + 1) % 7;
      end else if (inc_auto) begin
        m_carry = (m_day == n) ? 1 : 0;
        m_day = m_day % n + 1;
        m_wd  = (m_wd + 1) % 7;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_value",   int'(value),     m_day);
      chk("model_weekday", int'(weekday),   m_wd);
      chk("model_carry",   int'(carry_out), m_carry);
      chk("model_last",    int'(last_day),  (m_day == month_len(int'(dim))) ? 1 : 0);
    end
  end

  task automatic clr();
    inc_auto = 0; inc_manual = 0; dec_manual = 0; load_en = 0;
    load_day = 0; load_wday = 0;
  endtask

  // Advance one clock edge; inputs applied beforehand, cleared afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic load(input int d, input int w);
    load_en = 1; load_day = 5'(d); load_wday = 3'(w);
    tick();
  endtask

  initial begin
    rst = 1; dim = 6'd31;
    clr();
    repeat (2) tick();
    rst = 0;
    cmp_en = 1;
    tick();
    chk("reset_value", int'(value), 1);
    chk("reset_wday",  int'(weekday), 0);
    chk("reset_carry", int'(carry_out), 0);
    chk("reset_last",  int'(last_day), 0);

    // Asynchronous reset without a clock edge.
    load(15, 4);
    chk("load15", int'(value), 15);
    #2 rst = 1;
    #1;
    chk("async_rst_value", int'(value), 1);
    chk("async_rst_wday",  int'(weekday), 0);
    tick();
    rst = 0;
    tick(); tick();
    chk("hold_value", int'(value), 1);

    // Auto wrap at 30.
    dim = 6'd30;
    load(30, 6);
    inc_auto = 1; tick();
    chk("wrap30_value", int'(value), 1);
    chk("wrap30_wday",  int'(weekday), 0);
    chk("wrap30_carry", int'(carry_out), 1);
    inc_auto = 1; tick();
    chk("after_wrap_value", int'(value), 2);
    chk("after_wrap_carry", int'(carry_out), 0);

    // Leap February.
    dim = 6'd29;
    load(28, 0);
    inc_auto = 1; tick();
    chk("feb29_day29", int'(value), 29);
    chk("feb29_last",  int'(last_day), 1);
    inc_auto = 1; tick();
    chk("feb29_wrap",  int'(value), 1);
    chk("feb29_carry", int'(carry_out), 1);
    dim = 6'd28;
    load(27, 0);
    inc_auto = 1; tick();
    chk("feb28_day28", int'(value), 28);
    inc_auto = 1; tick();
    chk("feb28_wrap",  int'(value), 1);
    chk("feb28_carry", int'(carry_out), 1);
    dim = 6'd29;
    load(29, 3);
    dim = 6'd28; tick();
    chk("leap_clamp_value", int'(value), 28);
    chk("leap_clamp_carry", int'(carry_out), 0);

    // Manual set wraps without carry.
    dim = 6'd31;
    load(1, 0);
    dec_manual = 1; tick();
    chk("dec_wrap_value", int'(value), 31);
    chk("dec_wrap_wday",  int'(weekday), 6);
    chk("dec_wrap_carry", int'(carry_out), 0);
    inc_manual = 1; tick();
    chk("inc_wrap_value", int'(value), 1);
    chk("inc_wrap_carry", int'(carry_out), 0);

    // Priority: decrement beats increment and auto.
    load(10, 3);
    inc_auto = 1; inc_manual = 1; dec_manual = 1; tick();
    chk("prio_value", int'(value), 9);
    chk("prio_wday",  int'(weekday), 2);
    chk("prio_carry", int'(carry_out), 0);

    // Load saturation and weekday 7.
    dim = 6'd30;
    load(31, 7);
    chk("load_sat_value", int'(value), 30);
    chk("load_sat_wday",  int'(weekday), 0);
    load(0, 2);
    chk("load_zero_value", int'(value), 1);

    // Clamp beats a simultaneous auto pulse.
    dim = 6'd31;
    load(31, 5);
    dim = 6'd30; inc_auto = 1; tick();
    chk("clamp_value", int'(value), 30);
    chk("clamp_wday",  int'(weekday), 5);
    chk("clamp_carry", int'(carry_out), 0);

    // Out-of-range dim behaves as 31.
    dim = 6'd45;
    load(31, 1);
    chk("dim45_value", int'(value), 31);
    chk("dim45_last",  int'(last_day), 1);
    inc_auto = 1; tick();
    chk("dim45_wrap",  int'(value), 1);
    chk("dim45_carry", int'(carry_out), 1);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 5) == 0) dim = 6'($urandom_range(0, 63));
        else dim = 6'($urandom_range(28, 31));
      end
      inc_auto   = ($urandom_range(0, 1) == 0);
      inc_manual = ($urandom_range(0, 5) == 0);
      dec_manual = ($urandom_range(0, 5) == 0);
      load_en    = ($urandom_range(0, 9) == 0);
      load_day   = 5'($urandom_range(0, 31));
      load_wday  = 3'($urandom_range(0, 7));
      rst        = ($urandom_range(0, 199) == 0);
      tick();
      rst = 0;
    end

    tick();
    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
